// File: rtl/fir_controller_if.sv
// rtl/fir_controller_if.sv - handshake and datapath-control bundle between a sample source and fir_controller
interface fir_controller_if #(
  parameter int AddrWidth = 6
) ();
  logic                 in_valid;
  logic                 ready;
  logic                 shift;
  logic                 flush;
  logic                 freeze;
  logic [AddrWidth-1:0] address;
  logic                 out_valid;

  // upstream side: offers samples, observes sequencing
  modport master (
    output in_valid,
    input  ready, shift, flush, freeze, address, out_valid
  );

  // controller side
  modport slave (
    input  in_valid,
    output ready, shift, flush, freeze, address, out_valid
  );
endinterface

// File: rtl/fir_controller.sv
// rtl/fir_controller.sv - FIR MAC sequencer (IDLE/LOAD/MAC/DRAIN/DONE); optional macro FIR_BACK_TO_BACK_EN
module fir_controller #(
  parameter int FIR_size  = 64,
  parameter int AddrWidth = 6
) (
  input logic             clk,
  input logic             rst,
  fir_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // last tap index; the MAC phase ends after this address has been issued
  localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(FIR_size - 1);

  state_t               state_q;
  state_t               state_d;
  logic [AddrWidth-1:0] count_q;
  logic [AddrWidth-1:0] count_d;

  logic                 ready_o;
  logic                 shift_o;
  logic                 flush_o;
  logic                 freeze_o;
  logic [AddrWidth-1:0] address_o;
  logic                 out_valid_o;

  // state and tap counter registers; reset aborts any sequence in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // next-state logic plus Moore output decode from state and counter only
  always_comb begin
    state_d     = state_q;
    count_d     = '0;
    ready_o     = 1'b0;
    shift_o     = 1'b0;
    flush_o     = 1'b0;
    freeze_o    = 1'b1;
    address_o   = '0;
    out_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (bus.in_valid) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        // shift the new sample in and clear the product pipe and accumulator
        shift_o  = 1'b1;
        flush_o  = 1'b1;
        freeze_o = 1'b0;
        state_d  = MAC;
      end

      MAC: begin
        freeze_o  = 1'b0;
        address_o = count_q;
        if (count_q == LastTap) begin
          state_d = DRAIN;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      DRAIN: begin
        // one frozen cycle so the final product reaches the accumulator
        state_d = DONE;
      end

      DONE: begin
        out_valid_o = 1'b1;
`ifdef FIR_BACK_TO_BACK_EN
        ready_o = 1'b1;
        state_d = bus.in_valid ? LOAD : IDLE;
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready     = ready_o;
  assign bus.shift     = shift_o;
  assign bus.flush     = flush_o;
  assign bus.freeze    = freeze_o;
  assign bus.address   = address_o;
  assign bus.out_valid = out_valid_o;

endmodule

// File: doc/fir_controller.md
FIR_CONTROLLER -- requirements
Module: fir_controller

Interface
REQ-001 SHALL have parameter FIR_size, default 64: taps per output sample, and the number of MAC cycles.
REQ-002 SHALL have parameter AddrWidth, default 6: width of address; 2**AddrWidth SHALL be >= FIR_size.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  new sample present on the datapath din this cycle.
REQ-006 ready  output  1  controller accepts in_valid this cycle.
REQ-007 shift  output  1  datapath input-buffer shift strobe.
REQ-008 flush  output  1  clears datapath product pipe and accumulator.
REQ-009 freeze  output  1  forces datapath product pipe to zero so the accumulator holds.
REQ-010 address  output  AddrWidth  tap index driving buffer read and coefficient select.
REQ-011 out_valid  output  1  datapath dout holds the completed sum this cycle.

Function
REQ-012 SHALL be a Moore FSM with states IDLE, LOAD, MAC, DRAIN, DONE, plus an AddrWidth-bit tap counter; all outputs decode from state and counter only.
REQ-013 IDLE: ready=1, freeze=1, others 0, address=0; in_valid=1 SHALL go to LOAD, otherwise stay.
REQ-014 LOAD: exactly one cycle, shift=1, flush=1, freeze=0, address=0, ready=0; next state MAC with counter=0.
REQ-015 MAC: freeze=0, address=counter; counter SHALL increment by 1 per cycle from 0 to FIR_size-1 with no gaps or repeats; at counter=FIR_size-1 next state DRAIN, counter cleared.
REQ-016 DRAIN: exactly one cycle, freeze=1, address=0; lets the last product enter the accumulator; next DONE.
REQ-017 DONE: exactly one cycle, out_valid=1, freeze=1, address=0; next IDLE.
REQ-018 Latency: out_valid SHALL rise FIR_size+2 rising edges after the edge that samples in_valid=1 in IDLE.
REQ-019 in_valid while ready=0 SHALL be ignored: no queuing, no extra shift, no change in sequencing.
REQ-020 shift and flush SHALL never be high outside LOAD; out_valid SHALL never be high outside DONE.
REQ-021 The counter SHALL never exceed FIR_size-1 and SHALL not wrap during MAC.
REQ-022 freeze SHALL be high in every cycle except LOAD and MAC, so the datapath result stays stable between samples.

Reset
REQ-023 On a rising edge with rst=0, the state SHALL go to IDLE and the counter to 0, whatever the current state, including mid-MAC.
REQ-024 After reset: ready=1, freeze=1, shift=0, flush=0, out_valid=0, address=0.
REQ-025 A sequence aborted by reset SHALL produce no out_valid; the next accepted sample flushes the datapath in LOAD.

Configuration
REQ-026 Macro FIR_BACK_TO_BACK_EN.
- Defined: ready=1 also in DONE, and in_valid=1 in DONE SHALL go directly to LOAD while out_valid is still high that cycle.
- Not defined: ready=0 in DONE and DONE always goes to IDLE.

Verification
REQ-027 Reset: rst=0 for 2 cycles while in MAC at address=10 -> next cycle IDLE, ready=1, freeze=1, address=0; no out_valid afterwards.
REQ-028 Single sample: one-cycle in_valid pulse in IDLE, FIR_size=64 -> shift=flush=1 for 1 cycle, address 0..63 on 64 consecutive cycles, out_valid high for exactly 1 cycle, 66 edges after acceptance.
REQ-029 Ignored input: in_valid=1 at MAC address=20 -> no shift pulse, address sequence unchanged, out_valid timing unchanged.
REQ-030 Continuous in_valid=1, macro undefined -> shift pulses every 68 cycles; macro defined -> every 67 cycles, with LOAD directly after DONE.
REQ-031 Parameter FIR_size=4, AddrWidth=2 -> address 0,1,2,3 in MAC, out_valid 6 edges after acceptance.
REQ-032 Reference check with the datapath: coefficients all 1, samples 1..64 -> dout=2080 when out_valid=1, and dout still 2080 in the following IDLE cycles.
